// File: rtl/free_list_40x6_pkg.sv
// Shared types and constants for the 40-entry, 6-bit-index free-list allocator.
package free_list_pkg;

  localparam int unsigned NUM_ENTRIES = 40;
  localparam int unsigned IDX_W       = 6;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX   = idx_t'(NUM_ENTRIES - 1);
  localparam idx_t FULL_COUNT = idx_t'(NUM_ENTRIES);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  // Initial chain link: each entry points at its successor, the last wraps to 0.
  function automatic idx_t init_link(input idx_t i);
    return (i == LAST_IDX) ? '0 : i + idx_t'(1);
  endfunction

endpackage

// File: rtl/free_list_40x6_next_ptr.sv
// 40x6 next-pointer memory: one synchronous write port, one combinational read port.
module next_ptr_40x6
  import free_list_pkg::*;
(
  input  logic             R0_clk,
  input  logic             R0_en,
  input  logic [IDX_W-1:0] R0_addr,
  output logic [IDX_W-1:0] R0_data,
  input  logic             W0_clk,
  input  logic             W0_en,
  input  logic [IDX_W-1:0] W0_addr,
  input  logic [IDX_W-1:0] W0_data
);

  idx_t mem_q [NUM_ENTRIES];
  logic unused_r0_clk;

  // Read is asynchronous, so the read clock only exists for port symmetry.
  assign unused_r0_clk = R0_clk;

  always_ff @(posedge W0_clk) begin
    if (W0_en) begin
      mem_q[W0_addr] <= W0_data;
    end
  end

  always_comb begin
    R0_data = '0;
    if (R0_en) begin
      R0_data = mem_q[R0_addr];
    end
  end

endmodule

// File: rtl/free_list_40x6.sv
// Linked-list free-index allocator over a 40x6 next-pointer array.
// Optional double-free checking is enabled by FREE_LIST_DOUBLE_FREE_CHECK_EN.
module free_list_40x6
  import free_list_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  output logic             alloc_valid,
  input  logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             free_valid,
  output logic             free_ready,
  input  logic [IDX_W-1:0] free_idx,
  output logic [IDX_W-1:0] free_count,
  output logic             init_done
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  ,
  output logic             err_double_free
`endif
);

  state_e state_q, state_d;
  idx_t   init_cnt_q, init_cnt_d;
  idx_t   head_q, head_d;
  idx_t   tail_q, tail_d;
  idx_t   count_q, count_d;
  logic   init_done_q, init_done_d;

  logic   alloc_fire;
  logic   free_fire;
  logic   free_accept;

  logic   rd_en;
  idx_t   rd_data;
  logic   wr_en;
  idx_t   wr_addr;
  idx_t   wr_data;

  assign alloc_valid = (state_q == RUN) && (count_q != '0);
  assign free_ready  = (state_q == RUN);
  assign alloc_idx   = head_q;
  assign free_count  = count_q;
  assign init_done   = init_done_q;

  assign alloc_fire  = alloc_valid & alloc_ready;
  assign free_fire   = free_valid & free_ready;
  assign rd_en       = (state_q == RUN);

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic [NUM_ENTRIES-1:0] alloc_map_q, alloc_map_d;
  logic                   err_q, err_d;
  logic                   free_legal;

  // An index sitting at the head and popped this cycle may be returned immediately.
  always_comb begin
    free_legal = 1'b0;
    if (free_idx < FULL_COUNT) begin
      free_legal = alloc_map_q[free_idx] | (alloc_fire && (free_idx == head_q));
    end
    free_accept = free_fire & free_legal;
    err_d       = free_fire & ~free_legal;
    alloc_map_d = alloc_map_q;
    if (state_q == INIT) begin
      alloc_map_d = '0;
    end else begin
      if (alloc_fire) begin
        alloc_map_d[head_q] = 1'b1;
      end
      if (free_accept) begin
        alloc_map_d[free_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alloc_map_q <= '0;
      err_q       <= 1'b0;
    end else begin
      alloc_map_q <= alloc_map_d;
      err_q       <= err_d;
    end
  end

  assign err_double_free = err_q;
`else
  assign free_accept = free_fire;
`endif

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    init_done_d = init_done_q;
    wr_en       = 1'b0;
    wr_addr     = tail_q;
    wr_data     = free_idx;

    unique case (state_q)
      INIT: begin
        wr_en      = 1'b1;
        wr_addr    = init_cnt_q;
        wr_data    = init_link(init_cnt_q);
        init_cnt_d = init_cnt_q + idx_t'(1);
        if (init_cnt_q == LAST_IDX) begin
          head_d      = '0;
          tail_d      = LAST_IDX;
          count_d     = FULL_COUNT;
          init_done_d = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        unique case ({alloc_fire, free_accept})
          2'b10: begin
            head_d  = rd_data;
            count_d = count_q - idx_t'(1);
          end
          2'b01: begin
            tail_d  = free_idx;
            count_d = count_q + idx_t'(1);
            if (count_q == '0) begin
              head_d = free_idx;
            end else begin
              wr_en = 1'b1;
            end
          end
          2'b11: begin
            // With a single entry, head and tail alias; the freed index becomes the whole list.
            tail_d = free_idx;
            if (count_q == idx_t'(1)) begin
              head_d = free_idx;
            end else begin
              head_d = rd_data;
              wr_en  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      init_done_q <= init_done_d;
    end
  end

  next_ptr_40x6 u_next_ptr (
    .R0_clk  (clock),
    .R0_en   (rd_en),
    .R0_addr (head_q),
    .R0_data (rd_data),
    .W0_clk  (clock),
    .W0_en   (wr_en),
    .W0_addr (wr_addr),
    .W0_data (wr_data)
  );

endmodule

// File: tb/tb_free_list_40x6.sv
// Self-checking bench for free_list_40x6: queue-based reference model plus directed literal checks.
module tb_free_list_40x6;

  logic       clock;
  logic       reset;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [5:0] alloc_idx;
  logic       free_valid;
  logic       free_ready;
  logic [5:0] free_idx;
  logic [5:0] free_count;
  logic       init_done;
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic       err_double_free;
`endif

  free_list_40x6 dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_idx   (alloc_idx),
    .free_valid  (free_valid),
    .free_ready  (free_ready),
    .free_idx    (free_idx),
    .free_count  (free_count),
    .init_done   (init_done)
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    ,
    .err_double_free (err_double_free)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the free list is simply a FIFO of indices.
  int  mq[$];
  bit  allocated[40];
  int  init_left;
  bit  running;
  bit  exp_err;
  bit  model_live = 1'b0;

  always @(posedge clock) begin
    bit a_fire;
    bit legal;
    int popped;
    int fi;
    if (reset) begin
      mq.delete();
      foreach (allocated[k]) allocated[k] = 1'b0;
      init_left  = 40;
      running    = 1'b0;
      exp_err    = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      exp_err = 1'b0;
      if (!running) begin
        init_left--;
        if (init_left == 0) begin
          running = 1'b1;
          for (int i = 0; i < 40; i++) mq.push_back(i);
        end
      end else begin
        fi     = int'(free_idx);
        a_fire = alloc_ready && (mq.size() != 0);
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
        legal = (fi < 40) && (allocated[fi] || (a_fire && fi == mq[0]));
        if (free_valid && !legal) exp_err = 1'b1;
`else
        legal = 1'b1;
`endif
        if (a_fire) begin
          popped = mq.pop_front();
          allocated[popped] = 1'b1;
        end
        if (free_valid && legal) begin
          mq.push_back(fi);
          allocated[fi] = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (model_live && !reset) begin
      chk("init_done", int'(init_done), int'(running));
      chk("free_ready", int'(free_ready), int'(running));
      chk("alloc_valid", int'(alloc_valid), int'(running && mq.size() != 0));
      chk("free_count", int'(free_count), mq.size());
      if (running && mq.size() != 0) chk("alloc_idx", int'(alloc_idx), mq[0]);
      else if (!running)             chk("alloc_idx_init", int'(alloc_idx), 0);
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
      chk("err_double_free", int'(err_double_free), int'(exp_err));
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int seq[$];
    reset       = 1'b1;
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    free_idx    = '0;

    // Reset state and exact INIT length.
    do_reset();
    chk("rst_alloc_valid", int'(alloc_valid), 0);
    chk("rst_free_ready", int'(free_ready), 0);
    chk("rst_free_count", int'(free_count), 0);
    repeat (39) step();
    chk("init_done_at_39", int'(init_done), 0);
    step();
    chk("init_done_at_40", int'(init_done), 1);
    chk("full_count", int'(free_count), 40);
    chk("first_idx", int'(alloc_idx), 0);

    // Drain the whole list back to back.
    alloc_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      chk("drain_idx", int'(alloc_idx), i);
      step();
    end
    alloc_ready = 1'b0;
    chk("empty_valid", int'(alloc_valid), 0);
    chk("empty_count", int'(free_count), 0);

    // Free into an empty list.
    free_valid = 1'b1;
    free_idx   = 6'd7;
    step();
    free_valid = 1'b0;
    chk("free7_valid", int'(alloc_valid), 1);
    chk("free7_idx", int'(alloc_idx), 7);
    chk("free7_count", int'(free_count), 1);

    // Simultaneous alloc and free at count==1.
    alloc_ready = 1'b1;
    free_valid  = 1'b1;
    free_idx    = 6'd12;
    step();
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    chk("swap_idx", int'(alloc_idx), 12);
    chk("swap_count", int'(free_count), 1);
    step();
    chk("swap_hold_idx", int'(alloc_idx), 12);

    // Recycled indices land at the tail; simultaneous alloc/free at count>1.
    do_reset();
    repeat (40) step();
    alloc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pre_idx", int'(alloc_idx), i);
      step();
    end
    alloc_ready = 1'b0;
    free_valid  = 1'b1;
    free_idx    = 6'd2;
    step();
    free_idx    = 6'd0;
    step();
    free_valid  = 1'b0;
    chk("recycle_count", int'(free_count), 38);
    for (int i = 4; i < 40; i++) seq.push_back(i);
    seq.push_back(2);
    seq.push_back(0);
    seq.push_back(3);
    alloc_ready = 1'b1;
    foreach (seq[j]) begin
      chk("resume_idx", int'(alloc_idx), seq[j]);
      free_valid = (j == 0);
      free_idx   = 6'd3;
      step();
      free_valid = 1'b0;
    end
    alloc_ready = 1'b0;
    chk("resume_empty_valid", int'(alloc_valid), 0);
    chk("resume_empty_count", int'(free_count), 0);

    free_valid = 1'b1;
    free_idx   = 6'd5;
    step();
    free_valid = 1'b0;
    chk("free5_count", int'(free_count), 1);
    chk("free5_idx", int'(alloc_idx), 5);

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    // Index 5 is already free: dropped with a single-cycle error pulse.
    free_valid = 1'b1;
    free_idx   = 6'd5;
    step();
    free_valid = 1'b0;
    chk("dbl_err_pulse", int'(err_double_free), 1);
    chk("dbl_count", int'(free_count), 1);
    step();
    chk("dbl_err_clear", int'(err_double_free), 0);
    // Out-of-range index is likewise dropped.
    free_valid = 1'b1;
    free_idx   = 6'd45;
    step();
    free_valid = 1'b0;
    chk("oor_err_pulse", int'(err_double_free), 1);
    chk("oor_count", int'(free_count), 1);
    chk("oor_idx", int'(alloc_idx), 5);
    step();
    chk("oor_err_clear", int'(err_double_free), 0);
`endif

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
